load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store unit with lane steering,
//                load extension, alignment checks and a bus timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        is_store,
  input  logic [1:0]  store_sz,
  input  logic [2:0]  load_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic [2:0]  lsel_q, lsel_d;
  logic [1:0]  lane_q, lane_d;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misalign;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Access width decode; anything not byte or half is a word access.
  always_comb begin
    if (is_store) begin
      w_is_byte = (store_sz == 2'b00);
      w_is_half = (store_sz == 2'b01);
    end else begin
      w_is_byte = (load_sel == 3'b000) || (load_sel == 3'b011);
      w_is_half = (load_sel == 3'b001) || (load_sel == 3'b100);
    end
    w_misalign = (w_is_half && addr[0]) ||
                 (!w_is_byte && !w_is_half && (addr[1:0] != 2'b00));
  end

  always_comb begin
    if (w_is_byte) begin
      w_strb       = 4'b0001 << addr[1:0];
      w_wdata_lane = {4{wdata[7:0]}};
    end else if (w_is_half) begin
      w_strb       = 4'b0011 << {addr[1], 1'b0};
      w_wdata_lane = {2{wdata[15:0]}};
    end else begin
      w_strb       = 4'b1111;
      w_wdata_lane = wdata;
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lsel_q)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b011:  w_load_data = {24'd0, w_byte};
      3'b100:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    berr_d     = berr_q;
    lsel_d     = lsel_q;
    lane_d     = lane_q;
    stall      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    rdata      = 32'd0;
    bus_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (w_misalign) begin
            misaligned = 1'b1;
            done       = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_BUSY;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {addr[31:2], 2'b00};
            strb_d  = is_store ? w_strb : 4'b0000;
            wdata_d = is_store ? w_wdata_lane : 32'd0;
            lsel_d  = load_sel;
            lane_d  = addr[1:0];
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          // An ack on the final timeout cycle still completes normally.
          state_d = S_DONE;
          req_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : w_load_data;
          berr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == C_TIMEOUT_LAST) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            rdata_d = 32'd0;
            berr_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        rdata   = rdata_q;
        bus_err = berr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
      lsel_q  <= 3'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      lsel_q  <= lsel_d;
      lane_q  <= lane_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = strb_q;
  assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed plus randomized self-checking bench for
//                load_store_unit against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int unsigned C_TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic        is_store;
  logic [1:0]  store_sz;
  logic [2:0]  load_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYCLES(C_TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .is_store   (is_store),
    .store_sz   (store_sz),
    .load_sel   (load_sel),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned acc_bytes(input logic st, input logic [1:0] sz,
                                            input logic [2:0] ls);
    if (st) return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (ls == 3'd0 || ls == 3'd3) return 1;
    if (ls == 3'd1 || ls == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] ls, input logic [31:0] a,
                                           input logic [31:0] m);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    off = a % 4;
    b = (m >> (8 * off)) & 32'hFF;
    h = (m >> (16 * (off / 2))) & 32'hFFFF;
    case (ls)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return m;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input int unsigned n, input logic [31:0] wd);
    if (n == 1) return (wd % 256) * 32'h0101_0101;
    if (n == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // One full transaction; waits = number of no-ack BUSY cycles before ack.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic [2:0] ls,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits);
    int unsigned n;
    logic        acked;
    logic [3:0]  strb;
    n     = acc_bytes(st, sz, ls);
    acked = 1'b0;
    strb  = st ? 4'(((1 << n) - 1) << (a % 4)) : 4'd0;
    op_valid = 1'b1; is_store = st; store_sz = sz; load_sel = ls;
    addr = a; wdata = wd; mem_ack = 1'b0;
    #1;
    if ((a % n) != 0) begin
      chk("mis_flag",  {31'd0, misaligned}, 32'd1);
      chk("mis_done",  {31'd0, done}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      chk("mis_rdata", rdata, 32'd0);
      op_valid = 1'b0;
      tick;
      chk("mis_req",   {31'd0, mem_req}, 32'd0);
      chk("mis_after", {31'd0, done}, 32'd0);
      return;
    end
    chk("issue_stall", {31'd0, stall}, 32'd1);
    chk("issue_done",  {31'd0, done}, 32'd0);
    chk("issue_mis",   {31'd0, misaligned}, 32'd0);
    tick;
    for (int k = 0; k < int'(C_TO); k++) begin
      chk("busy_req",   {31'd0, mem_req}, 32'd1);
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_done",  {31'd0, done}, 32'd0);
      chk("busy_addr",  mem_addr, a - (a % 4));
      chk("busy_we",    {31'd0, mem_we}, {31'd0, st});
      chk("busy_strb",  {28'd0, mem_wstrb}, {28'd0, strb});
      if (st) chk("busy_wdata", mem_wdata, exp_wdata(n, wd));
      acked     = (k == waits);
      mem_ack   = acked;
      mem_rdata = acked ? rd : $urandom;
      tick;
      mem_ack = 1'b0;
      if (acked) break;
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req",   {31'd0, mem_req}, 32'd0);
    chk("done_berr",  {31'd0, bus_err}, {31'd0, !acked});
    chk("done_rdata", rdata, (acked && !st) ? exp_load(ls, a, rd) : 32'd0);
    mem_ack = 1'b1;
    op_valid = 1'b0;
    tick;
    mem_ack = 1'b0;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_berr", {31'd0, bus_err}, 32'd0);
    chk("idle_req",  {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    logic        st;
    logic [1:0]  sz;
    logic [2:0]  ls;
    logic [31:0] a;

    reset_n = 1'b0; op_valid = 1'b0; is_store = 1'b0; store_sz = 2'd0;
    load_sel = 3'd2; addr = 32'h100; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #2;
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_strb",  {28'd0, mem_wstrb}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_berr",  {31'd0, bus_err}, 32'd0);
    chk("rst_stall0", {31'd0, stall}, 32'd0);
    op_valid = 1'b1;
    #1;
    chk("rst_stall1", {31'd0, stall}, 32'd1);
    op_valid = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;

    do_op(1'b0, 2'd0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 0);
    do_op(1'b1, 2'd1, 3'd0, 32'h202, 32'h1234_ABCD, 32'd0, 0);
    do_op(1'b0, 2'd0, 3'd2, 32'h005, 32'd0, 32'd0, 0);
    do_op(1'b0, 2'd0, 3'd2, 32'h040, 32'd0, 32'd0, int'(C_TO));
    do_op(1'b0, 2'd0, 3'd4, 32'h012, 32'd0, 32'hF00D_0000, 3);

    op_valid = 1'b1; is_store = 1'b0; load_sel = 3'd2; addr = 32'h80;
    #1;
    tick;
    chk("rstbusy_req1", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstbusy_req0", {31'd0, mem_req}, 32'd0);
    op_valid = 1'b0;
    tick;
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rstbusy_nodone", {31'd0, done}, 32'd0);
    tick;
    mem_ack = 1'b0;
    chk("rstbusy_nodone2", {31'd0, done}, 32'd0);
    chk("rstbusy_req", {31'd0, mem_req}, 32'd0);
    op_valid = 1'b1;
    #1;
    chk("rstbusy_idle", {31'd0, stall}, 32'd1);
    op_valid = 1'b0;
    tick;

    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom);
      sz = 2'($urandom);
      ls = 3'($urandom);
      a  = $urandom;
      n  = acc_bytes(st, sz, ls);
      if ($urandom_range(0, 3) != 0) a = a - (a % n);
      do_op(st, sz, ls, a, $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
